// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per result producer, up to four
// slots granted round-robin each cycle onto registered forward channels A..D.
module cdb_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int PTR_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*22-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [22:0]           forwardA,
    output logic [22:0]           forwardB,
    output logic [22:0]           forwardC,
    output logic [22:0]           forwardD,
    output logic [PTR_W:0]        pending_count
);

    localparam int NCH   = 4;
    localparam int SLOTS = 1 << PTR_W;

    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] slot_valid_next;
    logic [NUM_REQ-1:0] granted;
    logic [NUM_REQ-1:0] accept;
    logic [21:0]        slot_data [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   last_idx;
    logic [PTR_W-1:0]   grant_idx [NCH];
    logic [NCH-1:0]     grant_valid;
    logic [PTR_W:0]     count_next;
    logic [22:0]        forward_next [NCH];
    logic [22:0]        forward_q [NCH];

    // Round-robin scan from rr_ptr; slot vectors are padded to 2^PTR_W so the
    // wrapped scan index can address them directly.
    always_comb begin
        logic [SLOTS-1:0] valid_pad;
        logic [SLOTS-1:0] granted_pad;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic [2:0]       cnt;
        valid_pad   = SLOTS'(slot_valid);
        granted_pad = '0;
        grant_valid = '0;
        last_idx    = rr_ptr;
        cnt         = '0;
        sum         = '0;
        idx         = '0;
        for (int c = 0; c < NCH; c++) grant_idx[c] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (valid_pad[idx] && !cnt[2]) begin
                granted_pad[idx]      = 1'b1;
                grant_idx[cnt[1:0]]   = idx;
                grant_valid[cnt[1:0]] = 1'b1;
                last_idx              = idx;
                cnt                   = cnt + 3'd1;
            end
        end
        granted = granted_pad[NUM_REQ-1:0];
    end

    always_comb begin
        logic [PTR_W:0] nxt;
        nxt     = {1'b0, last_idx} + (PTR_W+1)'(1);
        rr_next = (nxt == (PTR_W+1)'(NUM_REQ)) ? '0 : nxt[PTR_W-1:0];
    end

    assign req_ready = ~slot_valid | granted;
    assign accept    = req_valid & req_ready;

    always_comb begin
        slot_valid_next = (slot_valid & ~granted) | accept;
        count_next      = '0;
        for (int i = 0; i < NUM_REQ; i++)
            count_next = count_next + (PTR_W+1)'(slot_valid_next[i]);
    end

    // Channel muxes use constant slot indices so no out-of-range select exists.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            forward_next[c] = '0;
            for (int i = 0; i < NUM_REQ; i++)
                if (grant_valid[c] && grant_idx[c] == PTR_W'(i))
                    forward_next[c] = {1'b1, slot_data[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot_valid    <= '0;
            rr_ptr        <= '0;
            pending_count <= '0;
            for (int c = 0; c < NCH; c++) forward_q[c] <= '0;
        end else begin
            slot_valid    <= slot_valid_next;
            pending_count <= count_next;
            for (int c = 0; c < NCH; c++) forward_q[c] <= forward_next[c];
            if (|grant_valid) rr_ptr <= rr_next;
        end
    end

    // Payload needs no reset: it is only ever read behind slot_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (accept[i]) slot_data[i] <= req_data[22*i +: 22];
    end

    assign forwardA = forward_q[0];
    assign forwardB = forward_q[1];
    assign forwardC = forward_q[2];
    assign forwardD = forward_q[3];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table of directed vectors plus
// hand-written sequences for continuous contention and single-producer streaming.
module tb_cdb_arbiter;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [5:0]   req_valid;
    logic [131:0] req_data;
    logic [5:0]   req_ready;
    logic [22:0]  forwardA;
    logic [22:0]  forwardB;
    logic [22:0]  forwardC;
    logic [22:0]  forwardD;
    logic [4:0]   pending_count;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_REQ(6), .PTR_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .forwardA(forwardA),
        .forwardB(forwardB),
        .forwardC(forwardC),
        .forwardD(forwardD),
        .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         fl;
        logic [5:0]   valid;
        logic [131:0] data;
        logic [22:0]  fa, fb, fc, fd;
        logic [4:0]   pend;
        logic [5:0]   ready;
    } vec_t;

    vec_t vecs[$];
    logic [131:0] all_data;

    function automatic logic [21:0] pd(int p);
        return {6'(p + 10), 16'(16'hA000 + p)};
    endfunction

    function automatic logic [22:0] fw(int p);
        return {1'b1, pd(p)};
    endfunction

    task automatic addVec(logic rst, logic fl, logic [5:0] valid,
                          logic [22:0] fa, logic [22:0] fb, logic [22:0] fc,
                          logic [22:0] fd, logic [4:0] pend, logic [5:0] ready);
        vec_t v;
        v.rst = rst; v.fl = fl; v.valid = valid; v.data = all_data;
        v.fa = fa; v.fb = fb; v.fc = fc; v.fd = fd;
        v.pend = pend; v.ready = ready;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(logic rst, logic fl, logic [5:0] valid, logic [131:0] data);
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        req_valid = valid;
        req_data  = data;
        #1;
    endtask

    task automatic checkOutput(string name, logic [22:0] actual, logic [22:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        logic [131:0] d;
        logic [5:0]   mask;
        int           s;
        int           first;

        for (int p = 0; p < 6; p++) all_data[22*p +: 22] = pd(p);
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_data = all_data;

        // Each row: inputs for the coming edge, outputs expected before that edge.
        addVec(0,0,6'h3F, 0,0,0,0, 0, 6'h3F);
        addVec(1,0,6'h01, 0,0,0,0, 6, 6'h0F);
        addVec(0,0,6'h00, 0,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h04, 0,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h00, 0,0,0,0, 1, 6'h3F);
        addVec(0,0,6'h00, 23'h451234,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h11, 0,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h00, 0,0,0,0, 2, 6'h3F);
        addVec(0,0,6'h00, fw(4),fw(0),0,0, 0, 6'h3F);
        addVec(0,1,6'h00, 0,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h3F, 0,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h00, 0,0,0,0, 6, 6'h0F);
        addVec(0,0,6'h00, fw(0),fw(1),fw(2),fw(3), 2, 6'h3F);
        addVec(0,0,6'h00, fw(4),fw(5),0,0, 0, 6'h3F);
        addVec(0,0,6'h2A, 0,0,0,0, 0, 6'h3F);
        addVec(0,1,6'h01, 0,0,0,0, 3, 6'h3F);
        addVec(0,0,6'h00, 0,0,0,0, 0, 6'h3F);
        addVec(0,0,6'h00, 0,0,0,0, 0, 6'h3F);
        vecs[3].data[44 +: 22] = {6'd5, 16'h1234};

        applyStimulus(1, 0, 6'h00, all_data);
        applyStimulus(1, 0, 6'h00, all_data);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("v%0d.fwdA", i), forwardA, vecs[i].fa);
            checkOutput($sformatf("v%0d.fwdB", i), forwardB, vecs[i].fb);
            checkOutput($sformatf("v%0d.fwdC", i), forwardC, vecs[i].fc);
            checkOutput($sformatf("v%0d.fwdD", i), forwardD, vecs[i].fd);
            checkOutput($sformatf("v%0d.pending", i), {18'b0, pending_count}, {18'b0, vecs[i].pend});
            checkOutput($sformatf("v%0d.ready", i), {17'b0, req_ready}, {17'b0, vecs[i].ready});
        end

        // All producers hold requests: grant sets rotate {0..3},{4,5,0,1},{2..5}.
        applyStimulus(1, 0, 6'h00, all_data);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 0, 6'h3F, all_data);
            mask = 6'h3F;
            if (c >= 1) begin
                s = (c - 1) % 3;
                first = (4 * s) % 6;
                mask = '0;
                for (int j = 0; j < 4; j++) mask[(first + j) % 6] = 1'b1;
            end
            checkOutput($sformatf("hold%0d.ready", c), {17'b0, req_ready}, {17'b0, mask});
            if (c >= 2) begin
                s = (c - 2) % 3;
                first = (4 * s) % 6;
                checkOutput($sformatf("hold%0d.fwdA", c), forwardA, fw(first % 6));
                checkOutput($sformatf("hold%0d.fwdB", c), forwardB, fw((first + 1) % 6));
                checkOutput($sformatf("hold%0d.fwdC", c), forwardC, fw((first + 2) % 6));
                checkOutput($sformatf("hold%0d.fwdD", c), forwardD, fw((first + 3) % 6));
            end
        end

        // Producer 0 streams values 1..4 back to back.
        applyStimulus(1, 0, 6'h00, all_data);
        for (int k = 0; k < 6; k++) begin
            d = '0;
            d[21:0] = {6'd1, 16'(k + 1)};
            applyStimulus(0, 0, (k < 4) ? 6'h01 : 6'h00, d);
            checkOutput($sformatf("stream%0d.ready0", k), {22'b0, req_ready[0]}, 23'd1);
            if (k >= 2) begin
                checkOutput($sformatf("stream%0d.fwdA", k), forwardA, {1'b1, 6'd1, 16'(k - 1)});
                checkOutput($sformatf("stream%0d.fwdB", k), forwardB, 23'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
